// File: rtl/nic.sv
// nic: PE-to-router network interface with one output and one input packet buffer
module nic #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di
);
  logic [DATA_WIDTH-1:0] out_buf, in_buf;
  logic out_full, in_full;
  logic rd, wr;
  assign rd = nicEn & ~nicWrEn;
  assign wr = nicEn & nicWrEn & (addr == 2'b10);
  assign net_do = out_buf;
  assign net_so = reset & out_full & net_ro & (out_buf[DATA_WIDTH-1] == net_polarity);
  assign net_ri = reset & ~in_full;
  always_comb
    d_out = !rd            ? '0 :
            addr == 2'b00  ? in_buf :
            addr == 2'b01  ? {{(DATA_WIDTH-1){1'b0}}, in_full} :
            addr == 2'b10  ? out_buf :
                             {{(DATA_WIDTH-1){1'b0}}, out_full};
  always_ff @(posedge clk)
    if (!reset) begin
      out_buf  <= '0;
      out_full <= 1'b0;
      in_buf   <= '0;
      in_full  <= 1'b0;
    end else begin
      if (wr && !out_full) begin
        out_buf  <= d_in;
        out_full <= 1'b1;
      end else if (net_so)
        out_full <= 1'b0;
      if (net_si && net_ri) begin
        in_buf  <= net_di;
        in_full <= 1'b1;
      end else if (rd && addr == 2'b00)
        in_full <= 1'b0;
    end
endmodule

// File: tb/tb_nic.sv
// tb_nic: table-driven and sequence checks for nic
module tb_nic;
  localparam logic [63:0] A = 64'hC010_0000_1111_1111;
  localparam logic [63:0] B = 64'h0000_0000_2222_2222;
  localparam logic [63:0] D = 64'h0000_0000_0000_DEAD;
  localparam logic [63:0] E = 64'h0123_4567_89AB_CDEF;
  logic clk, reset, nicEn, nicWrEn, net_so, net_ro, net_polarity, net_si, net_ri;
  logic [1:0] addr;
  logic [63:0] d_in, d_out, net_do, net_di;
  int checks = 0, errors = 0;
  nic dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_ro(net_ro),
    .net_do(net_do), .net_polarity(net_polarity), .net_si(net_si),
    .net_ri(net_ri), .net_di(net_di)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic rst, en, we;
    logic [1:0] addr;
    logic [63:0] din;
    logic ro, pol, si;
    logic [63:0] di;
    logic [63:0] e_dout;
    logic e_so, e_ri;
    logic [63:0] e_do;
  } vec_t;
  vec_t v[33];
  function automatic vec_t mk(input logic rst, en, we, input logic [1:0] a, input logic [63:0] din,
                              input logic ro, pol, si, input logic [63:0] di, input logic [63:0] e_dout,
                              input logic e_so, e_ri, input logic [63:0] e_do);
    vec_t r;
    r.rst = rst; r.en = en; r.we = we; r.addr = a; r.din = din;
    r.ro = ro; r.pol = pol; r.si = si; r.di = di;
    r.e_dout = e_dout; r.e_so = e_so; r.e_ri = e_ri; r.e_do = e_do;
    return r;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  logic [63:0] pkt[4];
  int sent, wr_idx;
  initial begin
    v[0]  = mk(0,1,0,1, 0,1,0,0,0, 0,0,0,0);
    v[1]  = mk(1,1,0,3, 0,1,0,0,0, 0,0,1,0);
    v[2]  = mk(1,1,1,2, A,1,0,0,0, 0,0,1,0);
    v[3]  = mk(1,1,0,3, 0,1,0,0,0, 1,0,1,A);
    v[4]  = mk(1,1,0,3, 0,1,1,0,0, 1,1,1,A);
    v[5]  = mk(1,1,0,3, 0,1,0,0,0, 0,0,1,A);
    v[6]  = mk(1,1,1,2, A,0,1,0,0, 0,0,1,A);
    v[7]  = mk(1,1,0,3, 0,0,1,0,0, 1,0,1,A);
    v[8]  = mk(1,1,0,3, 0,0,1,0,0, 1,0,1,A);
    v[9]  = mk(1,1,0,3, 0,0,1,0,0, 1,0,1,A);
    v[10] = mk(1,1,0,3, 0,0,1,0,0, 1,0,1,A);
    v[11] = mk(1,1,1,2, D,0,1,0,0, 0,0,1,A);
    v[12] = mk(1,1,0,2, 0,0,1,0,0, A,0,1,A);
    v[13] = mk(1,1,0,2, 0,1,1,0,0, A,1,1,A);
    v[14] = mk(1,1,0,3, 0,1,1,0,0, 0,0,1,A);
    v[15] = mk(1,1,1,2, A,1,1,0,0, 0,0,1,A);
    v[16] = mk(1,1,1,2, D,1,1,0,0, 0,1,1,A);
    v[17] = mk(1,1,0,2, 0,0,1,0,0, A,0,1,A);
    v[18] = mk(1,1,0,3, 0,0,1,0,0, 0,0,1,A);
    v[19] = mk(1,1,0,1, 0,0,0,1,B, 0,0,1,A);
    v[20] = mk(1,1,0,1, 0,0,0,0,0, 1,0,0,A);
    v[21] = mk(1,1,0,0, 0,0,0,1,D, B,0,0,A);
    v[22] = mk(1,1,0,1, 0,0,0,0,0, 0,0,1,A);
    v[23] = mk(1,1,0,0, 0,0,0,0,0, B,0,1,A);
    v[24] = mk(1,1,0,1, 0,0,0,0,0, 0,0,1,A);
    v[25] = mk(1,1,1,2, E,0,0,1,B, 0,0,1,A);
    v[26] = mk(1,1,0,3, 0,0,0,0,0, 1,0,0,E);
    v[27] = mk(0,1,0,1, 0,1,0,0,0, 1,0,0,E);
    v[28] = mk(1,1,0,3, 0,1,0,0,0, 0,0,1,0);
    v[29] = mk(1,1,0,1, 0,1,0,0,0, 0,0,1,0);
    v[30] = mk(1,0,0,3, 0,0,0,0,0, 0,0,1,0);
    v[31] = mk(1,1,1,3, A,0,0,0,0, 0,0,1,0);
    v[32] = mk(1,1,0,3, 0,0,0,0,0, 0,0,1,0);
    reset = 0; nicEn = 0; nicWrEn = 0; addr = 0; d_in = 0;
    net_ro = 0; net_polarity = 0; net_si = 0; net_di = 0;
    @(posedge clk);
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      reset = v[i].rst; nicEn = v[i].en; nicWrEn = v[i].we; addr = v[i].addr; d_in = v[i].din;
      net_ro = v[i].ro; net_polarity = v[i].pol; net_si = v[i].si; net_di = v[i].di;
      #1;
      chk($sformatf("v%0d d_out", i), d_out, v[i].e_dout);
      chk($sformatf("v%0d net_so", i), {63'b0, net_so}, {63'b0, v[i].e_so});
      chk($sformatf("v%0d net_ri", i), {63'b0, net_ri}, {63'b0, v[i].e_ri});
      chk($sformatf("v%0d net_do", i), net_do, v[i].e_do);
    end
    pkt[0] = 64'h8000_0000_0000_00A0;
    pkt[1] = 64'h0000_0000_0000_00A1;
    pkt[2] = 64'h8000_0000_0000_00A2;
    pkt[3] = 64'h0000_0000_0000_00A3;
    sent = 0; wr_idx = 0;
    for (int c = 0; c < 200 && !(sent == 4 && c > 20); c++) begin
      @(negedge clk);
      reset = 1; net_si = 0; net_ro = 1; net_polarity = c[0];
      nicEn = 1; nicWrEn = 0; addr = 2'b11; d_in = 0;
      #1;
      if (net_so) begin
        if (sent < 4) begin
          chk($sformatf("b2b pkt%0d data", sent), net_do, pkt[sent]);
          chk($sformatf("b2b pkt%0d vc", sent), {63'b0, net_polarity}, {63'b0, pkt[sent][63]});
        end else
          chk("b2b extra send", {63'b0, net_so}, 64'd0);
        sent++;
      end
      if (d_out == 64'd0 && wr_idx < 4) begin
        nicWrEn = 1; addr = 2'b10; d_in = pkt[wr_idx];
        wr_idx++;
      end
    end
    chk("b2b sent count", sent, 4);
    chk("b2b written count", wr_idx, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
